// File: rtl/memarb_rr_if.sv
// Bundle of the private requester ports and the shared memory port of memarb_rr.
// The master modport is the arbiter's view; slave is the view of the
// surrounding requesters and memory controller.
//
// Handshake: a requester raises s_req with addr/data/wr stable and holds it
// until it sees s_ack, then drops s_req on the following edge. The shared
// port behaves the same way: req stays high until the controller returns a
// one-cycle ack, with read data on q in that same cycle.
interface memarb_rr_if #(
  parameter int N  = 4,
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int GN = 2
);
  logic [N*AN-1:0] s_addr;
  logic [N*DN-1:0] s_data;
  logic [N-1:0]    s_wr;
  logic [N-1:0]    s_req;
  logic [N-1:0]    s_ack;
  logic [DN-1:0]   s_q;
  logic [AN-1:0]   addr;
  logic [DN-1:0]   data;
  logic            wr;
  logic            req;
  logic            ack;
  logic [DN-1:0]   q;
  logic [GN-1:0]   grant;
  logic            active;
  logic            state_dbg;  // arbiter FSM state: 0 = IDLE, 1 = BUSY

  modport master (
    input  s_addr, s_data, s_wr, s_req, ack, q,
    output s_ack, s_q, addr, data, wr, req, grant, active, state_dbg
  );

  modport slave (
    output s_addr, s_data, s_wr, s_req, ack, q,
    input  s_ack, s_q, addr, data, wr, req, grant, active, state_dbg
  );
endinterface

// File: rtl/memarb_rr.sv
// Round-robin arbiter sharing one memory port among N req/ack requesters.
// Optional build macro MEMARB_PRIO0_EN: requester 0 becomes strict highest
// priority, round-robin applies among the others.
module memarb_rr #(
  parameter int N  = 4,
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int GN = 2
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  memarb_rr_if.master   bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GN-1:0] grant_q, grant_d;
  logic [GN-1:0] winner;
  logic          any_req;
  int            idx;

  assign any_req = |bus.s_req;

  // Winner search: upward from grant+1 modulo N; the last-served port is checked last
  always_comb begin
    winner = grant_q;
    idx    = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(grant_q) + k) % N;
`ifdef MEMARB_PRIO0_EN
      if (idx != 0 && bus.s_req[idx]) winner = GN'(idx);
`else
      if (bus.s_req[idx]) winner = GN'(idx);
`endif
    end
`ifdef MEMARB_PRIO0_EN
    if (bus.s_req[0]) winner = '0;
`endif
  end

  // Next-state logic: arbitrate in IDLE, wait for ack in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; grant resets to N-1 so requester 0 wins first
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      grant_q <= GN'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Ack routing: only the granted port sees the memory ack, and only while BUSY
  always_comb begin
    bus.s_ack = '0;
    for (int i = 0; i < N; i++) begin
      bus.s_ack[i] = (state_q == BUSY) && bus.ack && (grant_q == GN'(i));
    end
  end

  assign bus.addr      = bus.s_addr[int'(grant_q)*AN +: AN];
  assign bus.data      = bus.s_data[int'(grant_q)*DN +: DN];
  assign bus.wr        = bus.s_wr[grant_q];
  assign bus.req       = (state_q == BUSY);
  assign bus.active    = (state_q == BUSY);
  assign bus.s_q       = bus.q;
  assign bus.grant     = grant_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_memarb_rr.sv
// Directed bench for memarb_rr (N=4). Inputs change and outputs are sampled
// on the falling edge of clkSYS.
module tb_memarb_rr;
  localparam int N  = 4;
  localparam int AN = 24;
  localparam int DN = 16;
  localparam int GN = 2;

  logic clkSYS;
  logic n_reset;
  int   checks;
  int   errors;

  memarb_rr_if #(.N(N), .AN(AN), .DN(DN), .GN(GN)) bus ();

  memarb_rr #(.N(N), .AN(AN), .DN(DN), .GN(GN)) dut (
    .clkSYS  (clkSYS),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // Clock and reset
  initial clkSYS = 1'b0;
  always #5 clkSYS = ~clkSYS;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clkSYS);
    n_reset = 1'b0;
    @(negedge clkSYS);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset    = 1'b0;
    bus.s_addr = '0;
    bus.s_data = '0;
    bus.s_wr   = '0;
    bus.s_req  = '0;
    bus.ack    = 1'b0;
    bus.q      = '0;
    @(negedge clkSYS);
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.req); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", bus.active); end
    checks++; if (bus.s_ack !== 4'b0000) begin errors++; $display("FAIL reset_s_ack got %b exp 0000", bus.s_ack); end
    checks++; if (bus.grant !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d exp 3", bus.grant); end
    checks++; if (bus.state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", bus.state_dbg); end
    n_reset = 1'b1;
  endtask

  task automatic test_ack_idle();
    @(negedge clkSYS);
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_ack !== 4'b0000) begin errors++; $display("FAIL idle_ack_s_ack got %b exp 0000", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack = 1'b0;
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL idle_ack_active got %b exp 0", bus.active); end
  endtask

  task automatic test_single();
    @(negedge clkSYS);
    bus.s_addr[2*AN +: AN] = 24'h001234;
    bus.s_data[2*DN +: DN] = 16'hBEEF;
    bus.s_wr[2]  = 1'b1;
    bus.s_req    = 4'b0100;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", bus.req); end
    @(negedge clkSYS);
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL single_req_rise got %b exp 1", bus.req); end
    checks++; if (bus.grant !== 2'd2) begin errors++; $display("FAIL single_grant got %0d exp 2", bus.grant); end
    checks++; if (bus.addr !== 24'h001234) begin errors++; $display("FAIL single_addr got %h exp 001234", bus.addr); end
    checks++; if (bus.data !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h exp beef", bus.data); end
    checks++; if (bus.wr !== 1'b1) begin errors++; $display("FAIL single_wr got %b exp 1", bus.wr); end
    @(negedge clkSYS);
    @(negedge clkSYS);
    checks++; if (bus.s_ack !== 4'b0000) begin errors++; $display("FAIL single_no_early_ack got %b exp 0000", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_ack !== 4'b0100) begin errors++; $display("FAIL single_s_ack got %b exp 0100", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack   = 1'b0;
    bus.s_req = 4'b0000;
    bus.s_wr  = '0;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL single_req_fall got %b exp 0", bus.req); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL single_active_fall got %b exp 0", bus.active); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.s_req = 4'b0011;
    @(negedge clkSYS);
    checks++; if (bus.grant !== 2'd0) begin errors++; $display("FAIL simul_grant0 got %0d exp 0", bus.grant); end
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL simul_req0 got %b exp 1", bus.req); end
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_ack !== 4'b0001) begin errors++; $display("FAIL simul_ack0 got %b exp 0001", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack   = 1'b0;
    bus.s_req = 4'b0010;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL simul_gap got %b exp 0", bus.req); end
    @(negedge clkSYS);
    checks++; if (bus.grant !== 2'd1) begin errors++; $display("FAIL simul_grant1 got %0d exp 1", bus.grant); end
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL simul_req1 got %b exp 1", bus.req); end
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_ack !== 4'b0010) begin errors++; $display("FAIL simul_ack1 got %b exp 0010", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack   = 1'b0;
    bus.s_req = 4'b0000;
    @(negedge clkSYS);
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL simul_done got %b exp 0", bus.req); end
  endtask

  task automatic test_continuous();
    int cnt[4];
    int w;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    apply_reset();
    bus.s_req = 4'b1111;
    for (int t = 0; t < 40; t++) begin
      @(negedge clkSYS);
      w = 0;
      while (bus.req !== 1'b1 && w < 4) begin
        @(negedge clkSYS);
        w++;
      end
      checks++;
      if (bus.req !== 1'b1) begin
        errors++;
        $display("FAIL cont_timeout transfer %0d req got %b exp 1", t, bus.req);
        break;
      end
      checks++; if (bus.grant !== 2'(t % 4)) begin errors++; $display("FAIL cont_grant transfer %0d got %0d exp %0d", t, bus.grant, t % 4); end
      bus.ack = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) if (bus.s_ack[i] === 1'b1) cnt[i]++;
      @(negedge clkSYS);
      bus.ack = 1'b0;
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL cont_gap transfer %0d got %b exp 0", t, bus.req); end
    end
    bus.s_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] != 10) begin errors++; $display("FAIL cont_ack_count port %0d got %0d exp 10", i, cnt[i]); end
    end
  endtask

  task automatic test_read();
    @(negedge clkSYS);
    bus.s_addr[3*AN +: AN] = 24'hABCDEF;
    bus.s_wr  = 4'b0000;
    bus.s_req = 4'b1000;
    @(negedge clkSYS);
    checks++; if (bus.grant !== 2'd3) begin errors++; $display("FAIL read_grant got %0d exp 3", bus.grant); end
    checks++; if (bus.addr !== 24'hABCDEF) begin errors++; $display("FAIL read_addr got %h exp abcdef", bus.addr); end
    checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL read_wr got %b exp 0", bus.wr); end
    bus.q   = 16'h5A5A;
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_q !== 16'h5A5A) begin errors++; $display("FAIL read_s_q got %h exp 5a5a", bus.s_q); end
    checks++; if (bus.s_ack !== 4'b1000) begin errors++; $display("FAIL read_s_ack got %b exp 1000", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack   = 1'b0;
    bus.q     = '0;
    bus.s_req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    @(negedge clkSYS);
    bus.s_req = 4'b0100;
    @(negedge clkSYS);
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", bus.active); end
    #2;
    n_reset = 1'b0;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", bus.req); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rmid_active got %b exp 0", bus.active); end
    checks++; if (bus.grant !== 2'd3) begin errors++; $display("FAIL rmid_grant got %0d exp 3", bus.grant); end
    bus.s_req = 4'b0000;
    @(negedge clkSYS);
    n_reset = 1'b1;
    @(negedge clkSYS);
    bus.ack = 1'b1;
    #1;
    checks++; if (bus.s_ack !== 4'b0000) begin errors++; $display("FAIL rmid_stray_ack got %b exp 0000", bus.s_ack); end
    @(negedge clkSYS);
    bus.ack = 1'b0;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rmid_stay_idle got %b exp 0", bus.req); end
    bus.s_req = 4'b1001;
    @(negedge clkSYS);
    checks++; if (bus.grant !== 2'd0) begin errors++; $display("FAIL rmid_next_grant got %0d exp 0", bus.grant); end
    bus.ack = 1'b1;
    @(negedge clkSYS);
    bus.ack   = 1'b0;
    bus.s_req = 4'b0000;
  endtask

`ifdef MEMARB_PRIO0_EN
  task automatic test_prio0();
    logic       r0_tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_tab[7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
    apply_reset();
    bus.s_req = {1'b0, 1'b1, 1'b1, r0_tab[0]};
    for (int t = 0; t < 7; t++) begin
      @(negedge clkSYS);
      checks++; if (bus.grant !== exp_tab[t]) begin errors++; $display("FAIL prio0_grant transfer %0d got %0d exp %0d", t, bus.grant, exp_tab[t]); end
      bus.ack = 1'b1;
      @(negedge clkSYS);
      bus.ack = 1'b0;
      if (t < 6) bus.s_req[0] = r0_tab[t+1];
    end
    bus.s_req = 4'b0000;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ack_idle();
    test_single();
    test_simultaneous();
    test_continuous();
    test_read();
    test_reset_mid();
`ifdef MEMARB_PRIO0_EN
    test_prio0();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
